// File: rtl/ex_div_seq_pkg.sv
// ex_div_seq_pkg: shared op/state encodings and result constants for the EX-stage divider
package ex_div_seq_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} div_op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  localparam logic [XLEN-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] SIGNED_MIN = 32'h8000_0000;
endpackage

// File: rtl/ex_div_seq_if.sv
// ex_div_seq_if: pipeline <-> divider bundle; master = EX pipeline, slave = divider
// start/op/operands/flush flow to the divider; busy/valid/data flow back.
interface ex_div_seq_if #(parameter int DATA_WIDTH = 32);
  logic IDEX_DivStart;
  logic [1:0] IDEX_DivOp;
  logic [DATA_WIDTH-1:0] forward_rs1;
  logic [DATA_WIDTH-1:0] forward_rs2;
  logic EX_Flush;
  logic EX_DivBusy;
  logic EX_DivValid;
  logic [DATA_WIDTH-1:0] EX_DivData;
  modport master (output IDEX_DivStart, IDEX_DivOp, forward_rs1, forward_rs2, EX_Flush,
                  input EX_DivBusy, EX_DivValid, EX_DivData);
  modport slave (input IDEX_DivStart, IDEX_DivOp, forward_rs1, forward_rs2, EX_Flush,
                 output EX_DivBusy, EX_DivValid, EX_DivData);
endinterface

// File: rtl/ex_div_seq_div_step.sv
// div_step: one combinational restoring-divide step on {rem,quo}
// rem_i/quo_i/dvs_i: current partial remainder, quotient/dividend shifter, divisor
// rem_o/quo_o: values after shifting one dividend bit in and trying the subtract
module div_step #(parameter int DATA_WIDTH = 32) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] dvs_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);
  logic [DATA_WIDTH:0] shr, dif;
  logic ge;
  always_comb begin
    shr = {rem_i, quo_i[DATA_WIDTH-1]};
    dif = shr - {1'b0, dvs_i};
    ge = shr >= {1'b0, dvs_i};
    rem_o = ge ? dif[DATA_WIDTH-1:0] : shr[DATA_WIDTH-1:0];
    quo_o = {quo_i[DATA_WIDTH-2:0], ge};
  end
endmodule

// File: rtl/ex_div_seq.sv
// ex_div_seq: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer beside the EX ALU
// clk, rst_n (async active-low); bus (slave): start/op/rs1/rs2/flush in, busy/valid/data out.
// DIV_EARLY_OUT_EN: skip the dividend's leading zeros, latency becomes (significant bits + 1).
module ex_div_seq
  import ex_div_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 6
) (
  input logic clk,
  input logic rst_n,
  ex_div_seq_if.slave bus
);
  localparam int W = DATA_WIDTH;
  state_e state_q;
  logic [CNT_WIDTH-1:0] cnt_q, z;
  logic rem_op_q, qneg_q, rneg_q;
  logic [W-1:0] rem_q, quo_q, dvs_q, data_q;
  logic accept, sgn, s1, s2, div0, ovf, zero_skip, skip;
  logic [W-1:0] rs1, rs2, a1, a2, spec_res, rem_n, quo_n, quo_init;
  div_step #(.DATA_WIDTH(W)) u_step (.rem_i(rem_q), .quo_i(quo_q), .dvs_i(dvs_q), .rem_o(rem_n), .quo_o(quo_n));
  always_comb begin
    rs1 = bus.forward_rs1;
    rs2 = bus.forward_rs2;
    accept = state_q == IDLE && bus.IDEX_DivStart && !bus.EX_Flush;
    sgn = !bus.IDEX_DivOp[0];
    s1 = sgn & rs1[W-1];
    s2 = sgn & rs2[W-1];
    a1 = s1 ? -rs1 : rs1;
    a2 = s2 ? -rs2 : rs2;
    div0 = rs2 == '0;
    ovf = sgn && rs1 == SIGNED_MIN && rs2 == DIV_ZERO_QUO;
    skip = div0 | ovf | zero_skip;
    spec_res = div0 ? (bus.IDEX_DivOp[1] ? rs1 : DIV_ZERO_QUO) :
               (ovf && !bus.IDEX_DivOp[1]) ? SIGNED_MIN : '0;
    bus.EX_DivBusy = state_q == BUSY || accept;
    bus.EX_DivValid = state_q == DONE && !bus.EX_Flush;
    bus.EX_DivData = data_q;
  end
`ifdef DIV_EARLY_OUT_EN
  always_comb begin
    z = CNT_WIDTH'(W);
    for (int i = 0; i < W; i++) if (a1[i]) z = CNT_WIDTH'(W - 1 - i);
    quo_init = a1 << z;
    zero_skip = a1 == '0;
  end
`else
  always_comb begin
    z = '0;
    quo_init = a1;
    zero_skip = 1'b0;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_op_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      data_q <= '0;
    end else if (bus.EX_Flush && state_q != IDLE) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else if (accept) begin
      rem_op_q <= bus.IDEX_DivOp[1];
      qneg_q <= s1 ^ s2;
      rneg_q <= s1;
      rem_q <= '0;
      quo_q <= quo_init;
      dvs_q <= a2;
      if (skip) begin
        state_q <= DONE;
        cnt_q <= '0;
        data_q <= spec_res;
      end else begin
        state_q <= BUSY;
        cnt_q <= CNT_WIDTH'(W) - z;
      end
    end else if (state_q == BUSY) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CNT_WIDTH'(1)) begin
        state_q <= DONE;
        data_q <= rem_op_q ? (rneg_q ? -rem_n : rem_n) : (qneg_q ? -quo_n : quo_n);
      end
    end else if (state_q == DONE) begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_ex_div_seq.sv
// tb_ex_div_seq: random and directed check of ex_div_seq against a cycle-timeline reference model
module tb_ex_div_seq;
  import ex_div_seq_pkg::*;
  localparam int W = 32;
  localparam int NC = 40000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ex_div_seq_if #(.DATA_WIDTH(W)) bus();
  ex_div_seq #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  bit exp_busy[NC];
  bit exp_valid[NC];
  logic [31:0] exp_data[NC];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic [31:0] q, r;
    sgn = !op[0];
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = !op[0];
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`ifdef DIV_EARLY_OUT_EN
    begin
      logic [31:0] mag;
      int n;
      mag = (sgn && a[31]) ? -a : a;
      n = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
      return n == 0 ? 1 : n + 1;
    end
`else
    return 33;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && cyc < NC) begin
      check("busy", 32'(bus.EX_DivBusy), 32'(exp_busy[cyc]));
      check("valid", 32'(bus.EX_DivValid), 32'(exp_valid[cyc]));
      if (exp_valid[cyc]) check("data", bus.EX_DivData, exp_data[cyc]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int c, output int l);
    step();
    c = cyc;
    l = latency(op, a, b);
    bus.IDEX_DivStart = 1'b1;
    bus.IDEX_DivOp = op;
    bus.forward_rs1 = a;
    bus.forward_rs2 = b;
    bus.EX_Flush = 1'b0;
    for (int i = 0; i < l; i++) exp_busy[c + i] = 1'b1;
    exp_valid[c + l] = 1'b1;
    exp_data[c + l] = model(op, a, b);
    step();
    bus.IDEX_DivStart = 1'b0;
    bus.IDEX_DivOp = 2'($urandom_range(3));
    bus.forward_rs1 = $urandom;
    bus.forward_rs2 = $urandom;
  endtask

  // fk >= 1 flushes at accept+fk (fk <= latency); fk < 1 runs to completion
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int fk);
    int c, l;
    issue(op, a, b, c, l);
    if (fk >= 1) begin
      while (cyc < c + fk) step();
      bus.EX_Flush = 1'b1;
      for (int i = fk + 1; i < l; i++) exp_busy[c + i] = 1'b0;
      exp_valid[c + l] = 1'b0;
      step();
      bus.EX_Flush = 1'b0;
    end else begin
      while (cyc < c + l) step();
      if ($urandom_range(1) == 1) begin
        bus.IDEX_DivStart = 1'b1;
        bus.forward_rs1 = $urandom;
        bus.forward_rs2 = $urandom;
      end
      step();
      bus.IDEX_DivStart = 1'b0;
    end
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(2);
    for (int i = 0; i < n; i++) begin
      step();
      bus.IDEX_DivStart = $urandom_range(1) == 1;
      bus.EX_Flush = bus.IDEX_DivStart;
    end
    step();
    bus.IDEX_DivStart = 1'b0;
    bus.EX_Flush = 1'b0;
  endtask

  function automatic logic [31:0] pick_a();
    int s;
    s = $urandom_range(5);
    return s == 0 ? 32'h0 : s == 1 ? 32'h8000_0000 : s == 2 ? 32'hFFFF_FFFF :
           s == 3 ? 32'($urandom_range(1000)) : $urandom;
  endfunction

  function automatic logic [31:0] pick_b();
    int s;
    s = $urandom_range(6);
    return s == 0 ? 32'h0 : s == 1 ? 32'h1 : s == 2 ? 32'hFFFF_FFFF :
           s == 3 ? 32'($urandom_range(20)) : s == 4 ? -32'($urandom_range(20)) : $urandom;
  endfunction

  initial begin
    int c, l, fk;
    logic [1:0] op;
    logic [31:0] a, b;
    bus.IDEX_DivStart = 1'b0;
    bus.IDEX_DivOp = 2'b00;
    bus.forward_rs1 = '0;
    bus.forward_rs2 = '0;
    bus.EX_Flush = 1'b0;
    #2;
    check("rst_busy", 32'(bus.EX_DivBusy), 32'h0);
    check("rst_valid", 32'(bus.EX_DivValid), 32'h0);
    check("rst_data", bus.EX_DivData, 32'h0);
    check("m_divu", model(OP_DIVU, 100, 7), 32'd14);
    check("m_remu", model(OP_REMU, 100, 7), 32'd2);
    check("m_div_neg", model(OP_DIV, -32'd20, 3), 32'hFFFF_FFFA);
    check("m_rem_neg", model(OP_REM, -32'd20, 3), 32'hFFFF_FFFE);
    check("m_rem_negdvs", model(OP_REM, 20, -32'd3), 32'd2);
    check("m_divu_z", model(OP_DIVU, 5, 0), 32'hFFFF_FFFF);
    check("m_remu_z", model(OP_REMU, 5, 0), 32'd5);
    check("m_div_ovf", model(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("m_rem_ovf", model(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
    check("m_lat_z", 32'(latency(OP_DIVU, 5, 0)), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_op(OP_DIVU, 100, 7, -1);
    run_op(OP_REMU, 100, 7, -1);
    run_op(OP_DIV, -32'd20, 3, -1);
    run_op(OP_REM, -32'd20, 3, -1);
    run_op(OP_REM, 20, -32'd3, -1);
    run_op(OP_DIVU, 5, 0, -1);
    run_op(OP_REMU, 5, 0, -1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(OP_DIV, 1000, 10, 10);
    run_op(OP_DIVU, 9, 3, -1);
    issue(OP_DIV, 1000, 10, c, l);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int i = cyc; i < NC; i++) begin
      exp_busy[i] = 1'b0;
      exp_valid[i] = 1'b0;
    end
    #1;
    check("mid_rst_busy", 32'(bus.EX_DivBusy), 32'h0);
    check("mid_rst_valid", 32'(bus.EX_DivValid), 32'h0);
    check("mid_rst_data", bus.EX_DivData, 32'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_op(OP_DIVU, 32'hFFFF_FFFF, 1, -1);
    run_op(OP_REMU, 7, 7, -1);
    repeat (150) begin
      gap();
      op = 2'($urandom_range(3));
      a = pick_a();
      b = pick_b();
      l = latency(op, a, b);
      fk = $urandom_range(7) == 0 ? $urandom_range(l, 1) : -1;
      run_op(op, a, b, fk);
    end
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
